// File: rtl/vu_vmu_addr_gen_pkg.sv
// Shared definitions for the VMU address generator: widths, opcodes,
// command decode helpers, FSM encoding and the fence ack payload.
package vu_vmu_addr_gen_pkg;

  localparam int CMD_SZ    = 8;
  localparam int VLEN_SZ   = 11;
  localparam int ADDR_SZ   = 32;
  localparam int STRIDE_SZ = 32;
  localparam int OUTST_SZ  = 5;

  // Memory opcodes: [7:6]=2'b10, [5]=store, [4]=strided, [3:2]=0, [1:0]=log2 bytes
  localparam logic [CMD_SZ-1:0] CMD_FENCE  = 8'h01;
  localparam logic [CMD_SZ-1:0] CMD_LD_B   = 8'h80;
  localparam logic [CMD_SZ-1:0] CMD_LD_H   = 8'h81;
  localparam logic [CMD_SZ-1:0] CMD_LD_W   = 8'h82;
  localparam logic [CMD_SZ-1:0] CMD_LD_D   = 8'h83;
  localparam logic [CMD_SZ-1:0] CMD_LDS_W  = 8'h92;
  localparam logic [CMD_SZ-1:0] CMD_LDS_D  = 8'h93;
  localparam logic [CMD_SZ-1:0] CMD_ST_W   = 8'hA2;
  localparam logic [CMD_SZ-1:0] CMD_ST_D   = 8'hA3;
  localparam logic [CMD_SZ-1:0] CMD_STS_W  = 8'hB2;
  localparam logic [CMD_SZ-1:0] CMD_STS_D  = 8'hB3;

  localparam logic [31:0] FENCE_ACK = 32'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FENCE = 2'd2
  } state_t;

  function automatic logic is_fence(input logic [CMD_SZ-1:0] cmd);
    return (cmd == CMD_FENCE);
  endfunction

  function automatic logic is_mem(input logic [CMD_SZ-1:0] cmd);
    return (cmd[7:6] == 2'b10) && (cmd[3:2] == 2'b00);
  endfunction

  function automatic logic is_strided(input logic [CMD_SZ-1:0] cmd);
    return cmd[4];
  endfunction

  function automatic logic is_store(input logic [CMD_SZ-1:0] cmd);
    return cmd[5];
  endfunction

  function automatic logic [1:0] elem_log2(input logic [CMD_SZ-1:0] cmd);
    return cmd[1:0];
  endfunction

endpackage

// File: rtl/vu_vmu_addr_gen_outst.sv
// Saturating up/down counter of in-flight memory requests with full/empty flags.
module vu_vmu_outst_ctr
  import vu_vmu_addr_gen_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [OUTST_SZ-1:0] cnt_r;
  logic inc_ok_s;
  logic dec_ok_s;

  assign full     = &cnt_r;
  assign empty    = (cnt_r == {OUTST_SZ{1'b0}});
  assign inc_ok_s = inc && !full;
  assign dec_ok_s = dec && !empty;

  // Count update; simultaneous issue and completion cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {OUTST_SZ{1'b0}};
    end else if (inc_ok_s && !dec_ok_s) begin
      cnt_r <= cnt_r + {{(OUTST_SZ-1){1'b0}}, 1'b1};
    end else if (dec_ok_s && !inc_ok_s) begin
      cnt_r <= cnt_r - {{(OUTST_SZ-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/vu_vmu_addr_gen.sv
// VMU front stage: turns one vector memory command into a stream of element
// address requests and answers fences once all issued requests completed.
module vu_vmu_addr_gen
  import vu_vmu_addr_gen_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CMD_SZ+VLEN_SZ-1:0]  vcmdq_bits,
  input  logic                       vcmdq_val,
  output logic                       vcmdq_rdy,
  input  logic [ADDR_SZ-1:0]         vbaseq_bits,
  input  logic                       vbaseq_val,
  output logic                       vbaseq_rdy,
  input  logic [STRIDE_SZ-1:0]       vstrideq_bits,
  input  logic                       vstrideq_val,
  output logic                       vstrideq_rdy,
  output logic [ADDR_SZ-1:0]         req_addr,
  output logic                       req_store,
  output logic [1:0]                 req_size,
  output logic                       req_val,
  input  logic                       req_rdy,
  input  logic                       resp_done,
  output logic [31:0]                vackq_bits,
  output logic                       vackq_val,
  input  logic                       vackq_rdy
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ADDR_SZ-1:0]   addr_r;
  logic [STRIDE_SZ-1:0] stride_r;
  logic [VLEN_SZ-1:0]   count_r;
  logic                 store_r;
  logic [1:0]           size_r;

  logic [CMD_SZ-1:0]    cmd_s;
  logic [VLEN_SZ-1:0]   vlen_m1_s;
  logic                 mem_fire_s;
  logic                 req_fire_s;
  logic                 outst_full_s;
  logic                 outst_empty_s;

  assign cmd_s      = vcmdq_bits[CMD_SZ+VLEN_SZ-1:VLEN_SZ];
  assign vlen_m1_s  = vcmdq_bits[VLEN_SZ-1:0];
  assign req_fire_s = req_val && req_rdy;
  assign req_addr   = addr_r;
  assign req_store  = store_r;
  assign req_size   = size_r;

  vu_vmu_outst_ctr u_outst (
    .clk   (clk),
    .reset (reset),
    .inc   (req_fire_s),
    .dec   (resp_done),
    .full  (outst_full_s),
    .empty (outst_empty_s)
  );

  // Next state and handshakes; everything is held off while reset is high
  always_comb begin
    state_nxt_s  = state_r;
    vcmdq_rdy    = 1'b0;
    vbaseq_rdy   = 1'b0;
    vstrideq_rdy = 1'b0;
    req_val      = 1'b0;
    vackq_val    = 1'b0;
    vackq_bits   = 32'd0;
    mem_fire_s   = 1'b0;
    if (reset) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!vcmdq_val) begin
            state_nxt_s = S_IDLE;
          end else if (is_fence(cmd_s)) begin
            vcmdq_rdy   = 1'b1;
            state_nxt_s = S_FENCE;
          end else if (is_mem(cmd_s)) begin
            // All operand queues dequeue together or not at all
            if (vbaseq_val && (!is_strided(cmd_s) || vstrideq_val)) begin
              mem_fire_s   = 1'b1;
              vcmdq_rdy    = 1'b1;
              vbaseq_rdy   = 1'b1;
              vstrideq_rdy = is_strided(cmd_s);
              state_nxt_s  = S_ISSUE;
            end else begin
              state_nxt_s = S_IDLE;
            end
          end else begin
            vcmdq_rdy = 1'b1;
          end
        end
        S_ISSUE: begin
          if (!outst_full_s) begin
            req_val = 1'b1;
            if (req_rdy && (count_r == {VLEN_SZ{1'b0}})) begin
              state_nxt_s = S_IDLE;
            end else begin
              state_nxt_s = S_ISSUE;
            end
          end else begin
            state_nxt_s = S_ISSUE;
          end
        end
        S_FENCE: begin
          if (outst_empty_s && !resp_done) begin
            vackq_val  = 1'b1;
            vackq_bits = FENCE_ACK;
            if (vackq_rdy) begin
              state_nxt_s = S_IDLE;
            end else begin
              state_nxt_s = S_FENCE;
            end
          end else begin
            state_nxt_s = S_FENCE;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command latch and per-element address/count advance
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r   <= {ADDR_SZ{1'b0}};
      stride_r <= {STRIDE_SZ{1'b0}};
      count_r  <= {VLEN_SZ{1'b0}};
      store_r  <= 1'b0;
      size_r   <= 2'd0;
    end else if (mem_fire_s) begin
      addr_r   <= vbaseq_bits;
      stride_r <= is_strided(cmd_s) ? vstrideq_bits
                                    : ({{(STRIDE_SZ-1){1'b0}}, 1'b1} << elem_log2(cmd_s));
      count_r  <= vlen_m1_s;
      store_r  <= is_store(cmd_s);
      size_r   <= elem_log2(cmd_s);
    end else if (req_fire_s && (count_r != {VLEN_SZ{1'b0}})) begin
      addr_r  <= addr_r + ADDR_SZ'($signed(stride_r));
      count_r <= count_r - {{(VLEN_SZ-1){1'b0}}, 1'b1};
    end else begin
      addr_r  <= addr_r;
      count_r <= count_r;
    end
  end

endmodule
